c5_mac_accum_drain: RTL and testbench

Result-side drain for the C5 four-way 8-bit MAC DSP wrappers. The MAC wrappers ignore handshakes and have a fixed pipeline latency. This block gates operand issue into the MAC, tracks in-flight issues with a tag delay line, and accumulates the sign-extended 32-bit MAC results into saturating dot-product sums. Completed sums go to a small output FIFO with a valid/ready interface. It sits between the MAC instance and the PE output/drain network.

---
 rtl/c5_mac_accum_drain.sv | 146 ++++++++++++++
 tb/tb_c5_mac_accum_drain.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/c5_mac_accum_drain.sv
// Result-side drain for the C5 MAC: issue gating, tag delay line, saturating accumulate, output FIFO.
// Latency MAC_LATENCY+1 from a last issue to out_valid; op_ready is credit-based from registered state only.

module c5_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     not_empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // First-word fall-through: head is the entry at the read pointer.
    assign head      = mem[rd_ptr];
    assign not_empty = (count != '0);
    assign full      = (count == DEPTH_C);
endmodule

module c5_mac_accum_drain #(
    parameter int MAC_LATENCY = 3,
    parameter int ACC_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 op_valid,
    input  logic                 op_last,
    output logic                 op_ready,
    input  logic [ACC_WIDTH-1:0] mac_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                   issue;
    logic [MAC_LATENCY-1:0] tag_vld;
    logic [MAC_LATENCY-1:0] tag_last;
    logic [7:0]             reserved;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;
    logic [ACC_WIDTH-1:0]   acc;
    logic                   ovf;
    logic [ACC_WIDTH:0]     sum_ext;
    logic                   clamped;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   ovf_next;

    assign issue = op_valid & op_ready;

    // The MAC cannot stall, so the tag line shifts unconditionally.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tag_vld  <= '0;
            tag_last <= '0;
        end else begin
            tag_vld[0]  <= issue;
            tag_last[0] <= issue & op_last;
            for (int i = 1; i < MAC_LATENCY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_last[i] <= tag_last[i-1];
            end
        end
    end

    // Every last tag in flight owns a FIFO slot, so a push never finds the FIFO full.
    always_comb begin
        reserved = 8'(fifo_count);
        for (int i = 0; i < MAC_LATENCY; i++) reserved = reserved + {7'd0, tag_last[i]};
    end
    assign op_ready = (reserved < 8'(FIFO_DEPTH));

    assign sum_ext  = {acc[ACC_WIDTH-1], acc} + {mac_result[ACC_WIDTH-1], mac_result};
    assign clamped  = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
    assign acc_next = !clamped          ? sum_ext[ACC_WIDTH-1:0] :
                      sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                           {1'b0, {(ACC_WIDTH-1){1'b1}}};
    assign ovf_next = ovf | clamped;
    assign push     = tag_vld[MAC_LATENCY-1] & tag_last[MAC_LATENCY-1];
    assign pop      = out_valid & out_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (tag_vld[MAC_LATENCY-1]) begin
            if (tag_last[MAC_LATENCY-1]) begin
                acc <= '0;
                ovf <= 1'b0;
            end else begin
                acc <= acc_next;
                ovf <= ovf_next;
            end
        end
    end

    c5_fifo #(.W(ACC_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (push),
        .push_data ({ovf_next, acc_next}),
        .pop       (pop),
        .head      ({out_overflow, out_data}),
        .not_empty (out_valid),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    push_into_full: assert property (@(posedge clock) disable iff (!resetn) !(push && fifo_full))
        else $error("c5_mac_accum_drain: push into full FIFO");
endmodule

// File: tb/tb_c5_mac_accum_drain.sv
// Directed bench for c5_mac_accum_drain with a fixed-latency MAC model feeding mac_result.
module tb_c5_mac_accum_drain;
    localparam int L = 3;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_last = 1'b0;
    logic        op_ready;
    logic [31:0] mac_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_overflow;

    logic [31:0] cur_val = '0;
    logic [31:0] mac_pipe [L];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    c5_mac_accum_drain #(.MAC_LATENCY(L), .ACC_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .op_valid     (op_valid),
        .op_last      (op_last),
        .op_ready     (op_ready),
        .mac_result   (mac_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow)
    );

    always #5 clock = ~clock;

    // MAC model: the value presented in cycle t appears on mac_result in cycle t+L, regardless of handshake.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        mac_pipe[0] <= cur_val;
        for (int i = 1; i < L; i++) mac_pipe[i] <= mac_pipe[i-1];
    end
    assign mac_result = mac_pipe[L-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the issue, t = issue cycle.
    task automatic send(input logic [31:0] v, input logic last, output int t);
        int n = 0;
        op_valid = 1'b1;
        op_last  = last;
        cur_val  = v;
        while (!op_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!op_ready) check("send_ready", 32'(op_ready), 32'd1);
        t = cyc;
        @(negedge clock);
        op_valid = 1'b0;
        op_last  = 1'b0;
        cur_val  = '0;
    endtask

    task automatic expect_pop(input string tag, input logic [31:0] d, input logic o);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_dat"}, out_data, d);
        check({tag, "_ovf"}, 32'(out_overflow), 32'(o));
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    initial begin
        int t;
        int n;
        int issued;
        int npop;
        int t4;
        int pop1;

        #2 resetn = 1'b0;
        #1;
        check("rst_ready", 32'(op_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_ovf", 32'(out_overflow), 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Four-term dot product and its latency.
        send(32'd10, 1'b0, t);
        send(-32'sd3, 1'b0, t);
        send(32'd7, 1'b0, t);
        send(32'd100, 1'b1, t);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("t1_latency", cyc, t + L + 1);
        expect_pop("t1", 32'd114, 1'b0);
        check("t1_empty", 32'(out_valid), 32'd0);

        // Single-term sums back to back.
        send(-32'sd5, 1'b1, t);
        send(32'd4, 1'b1, t);
        expect_pop("single_a", 32'hFFFF_FFFB, 1'b0);
        expect_pop("single_b", 32'd4, 1'b0);

        // Saturation, then a clean sum.
        send(32'h7FFF_FF00, 1'b0, t);
        send(32'h7FFF_FF00, 1'b0, t);
        send(32'h7FFF_FF00, 1'b0, t);
        send(32'hFFFF_FFFF, 1'b1, t);
        send(32'd2, 1'b0, t);
        send(32'd3, 1'b1, t);
        expect_pop("sat", 32'h7FFF_FFFE, 1'b1);
        expect_pop("after_sat", 32'd5, 1'b0);

        // Backpressure: six single-term sums against a stalled output.
        issued = 0; npop = 0; t4 = -1; pop1 = -1;
        op_last = 1'b1;
        for (int k = 0; k < 60 && npop < 6; k++) begin
            if (k == 12) begin
                check("bp_blocked", issued, 32'd4);
                out_ready = 1'b1;
            end
            if (t4 >= 0 && cyc == t4 + 1) check("bp_ready_drop", 32'(op_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (pop1 < 0) pop1 = cyc;
                check("bp_order", out_data, 32'(200 + npop));
                npop++;
            end
            if (pop1 >= 0 && cyc == pop1) check("bp_ready_at_pop", 32'(op_ready), 32'd0);
            if (pop1 >= 0 && cyc == pop1 + 1) check("bp_ready_after_pop", 32'(op_ready), 32'd1);
            op_valid = (issued < 6);
            cur_val  = 32'(200 + issued);
            if (op_valid && op_ready) begin
                issued++;
                if (issued == 4) t4 = cyc;
            end
            @(negedge clock);
        end
        op_valid = 1'b0; op_last = 1'b0; out_ready = 1'b0;
        check("bp_pops", npop, 32'd6);
        check("bp_issued", issued, 32'd6);

        // Push and pop in the same cycle with every slot reserved.
        send(32'd300, 1'b1, t);
        send(32'd301, 1'b1, t);
        send(32'd302, 1'b1, t);
        send(32'd303, 1'b1, t);
        check("pp_ready_full", 32'(op_ready), 32'd0);
        n = 0;
        while (cyc < t + L && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("pp_ready_before", 32'(op_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("pp_vld", 32'(out_valid), 32'd1);
            check("pp_order", out_data, 32'(300 + k));
            if (k == 1) check("pp_ready_after", 32'(op_ready), 32'd1);
            @(negedge clock);
        end
        out_ready = 1'b0;
        check("pp_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-sum with a completed sum waiting and two tags in flight.
        send(32'd77, 1'b1, t);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("rs_pending", out_data, 32'd77);
        send(32'd50, 1'b0, t);
        send(32'd60, 1'b0, t);
        #2 resetn = 1'b0;
        #1;
        check("rs_valid", 32'(out_valid), 32'd0);
        check("rs_data", out_data, 32'd0);
        check("rs_ovf", 32'(out_overflow), 32'd0);
        check("rs_ready", 32'(op_ready), 32'd1);
        @(negedge clock);
        resetn = 1'b1;
        send(32'd9, 1'b1, t);
        expect_pop("rs_next", 32'd9, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
